// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if
//   Request/response channel between a CPU data-memory port and the memory
//   that answers it. Both directions use a valid/ready handshake.
//
//   Request channel  (requester -> responder):
//     req_valid, req_a (byte address), req_we (1 = store), req_wd (store data)
//     req_ready (responder -> requester)
//   Response channel (responder -> requester):
//     resp_valid, resp_rd (load data), resp_err (misaligned / out of range)
//     resp_ready (requester -> responder)
//
//   Modports: master = requester (CPU side), slave = responder (memory side).
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic        req_we;
  logic [31:0] req_wd;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rd;
  logic        resp_err;

  modport master (
    output req_valid, req_a, req_we, req_wd, resp_ready,
    input  req_ready, resp_valid, resp_rd, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_we, req_wd, resp_ready,
    output req_ready, resp_valid, resp_rd, resp_err
  );
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Word-organised data RAM answering CPU load/store requests. A request is
//   accepted in IDLE, optionally held for WAIT_STATES cycles, performed, and
//   its result is presented until the requester takes it.
//
//   Parameters:
//     ADDR_W      - log2 of RAM depth in 32-bit words
//     WAIT_STATES - extra cycles between request accept and the access
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset (RAM contents are not reset)
//     bus    - slave side of data_memory_responder_if
module data_memory_responder #(
  parameter int ADDR_W      = 6,
  parameter int WAIT_STATES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  data_memory_responder_if.slave   bus
);

  localparam int CNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               capture;
  logic               do_access;

  logic [31:0]        lat_a;
  logic               lat_we;
  logic [31:0]        lat_wd;

  logic [31:0]        acc_a;
  logic               acc_we;
  logic [31:0]        acc_wd;
  logic [ADDR_W-1:0]  acc_idx;
  logic               acc_err;

  logic [31:0]        rd_q;
  logic               err_q;

  logic [31:0]        mem [0:DEPTH-1];

  // The access uses the live request fields when it happens on the accept
  // edge itself (zero wait states), otherwise the copy latched at accept.
  always_comb begin
    acc_a  = bus.req_a;
    acc_we = bus.req_we;
    acc_wd = bus.req_wd;
    if (state == S_WAIT) begin
      acc_a  = lat_a;
      acc_we = lat_we;
      acc_wd = lat_wd;
    end
  end

  // Misaligned addresses and any set bit above the RAM's word range are
  // rejected without touching the array.
  assign acc_idx = acc_a[ADDR_W+1:2];
  assign acc_err = (acc_a[1:0] != 2'b00) || (acc_a[31:ADDR_W+2] != '0);

  // Next-state and control decode. The counter is loaded at accept and the
  // access fires on the edge where it reads 1, which gives a response
  // WAIT_STATES+1 cycles after the accept cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    do_access  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            do_access  = 1'b1;
            state_next = S_RESP;
          end else begin
            cnt_next   = CNT_W'(WAIT_STATES);
            state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          do_access  = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Latched request and response registers. The response holds its value
  // after the handshake so the outputs stay quiet in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_a  <= '0;
      lat_we <= 1'b0;
      lat_wd <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      if (capture) begin
        lat_a  <= bus.req_a;
        lat_we <= bus.req_we;
        lat_wd <= bus.req_wd;
      end
      if (do_access) begin
        err_q <= acc_err;
        rd_q  <= (acc_err || acc_we) ? 32'h0 : mem[acc_idx];
      end
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_access && acc_we && !acc_err) begin
      mem[acc_idx] <= acc_wd;
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rd    = rd_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder
//   Directed bench for data_memory_responder: a default instance
//   (WAIT_STATES=2, ADDR_W=6) and a zero-wait-state instance, each with
//   its own interface and reset.
module tb_data_memory_responder;

  logic clk;
  logic rst_n;
  logic rst0_n;

  int pass_cnt  = 0;
  int check_cnt = 0;

  data_memory_responder_if bus0 ();
  data_memory_responder_if bus1 ();

  data_memory_responder #(.ADDR_W(6), .WAIT_STATES(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  data_memory_responder #(.ADDR_W(6), .WAIT_STATES(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst0_n),
    .bus   (bus1.slave)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    check_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one full transaction on the default instance and return its result.
  task automatic applyStimulus(input logic we, input logic [31:0] a,
                               input logic [31:0] wd,
                               output logic [31:0] rd, output logic err);
    int n;
    bus0.req_valid  = 1'b1;
    bus0.req_we     = we;
    bus0.req_a      = a;
    bus0.req_wd     = wd;
    bus0.resp_ready = 1'b0;
    n = 0;
    while (!bus0.req_ready && n < 50) begin
      step();
      n++;
    end
    step();
    bus0.req_valid = 1'b0;
    n = 0;
    while (!bus0.resp_valid && n < 50) begin
      step();
      n++;
    end
    checkOutput("txn_resp_valid", {31'b0, bus0.resp_valid}, 32'd1);
    rd  = bus0.resp_rd;
    err = bus0.resp_err;
    bus0.resp_ready = 1'b1;
    step();
    bus0.resp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;

  initial begin
    rst_n  = 1'b0;
    rst0_n = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_a = '0; bus0.req_we = 1'b0;
    bus0.req_wd = '0; bus0.resp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_a = '0; bus1.req_we = 1'b0;
    bus1.req_wd = '0; bus1.resp_ready = 1'b0;
    step();
    step();
    checkOutput("rst_req_ready",  {31'b0, bus0.req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'b0, bus0.resp_valid}, 32'd0);
    checkOutput("rst_resp_rd",    bus0.resp_rd, 32'd0);
    checkOutput("rst_resp_err",   {31'b0, bus0.resp_err}, 32'd0);
    rst_n  = 1'b1;
    rst0_n = 1'b1;
    step();

    // Scenario 1: store timing, then read back.
    $display("[TB] scenario 1: store/load latency");
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1;
    bus0.req_a = 32'h10; bus0.req_wd = 32'h12345678;
    checkOutput("s1_c0_ready", {31'b0, bus0.req_ready}, 32'd1);
    step();
    bus0.req_valid = 1'b0;
    checkOutput("s1_c1_ready", {31'b0, bus0.req_ready}, 32'd0);
    checkOutput("s1_c1_valid", {31'b0, bus0.resp_valid}, 32'd0);
    step();
    checkOutput("s1_c2_valid", {31'b0, bus0.resp_valid}, 32'd0);
    step();
    checkOutput("s1_c3_valid", {31'b0, bus0.resp_valid}, 32'd1);
    checkOutput("s1_c3_err",   {31'b0, bus0.resp_err}, 32'd0);
    checkOutput("s1_c3_rd",    bus0.resp_rd, 32'd0);
    bus0.resp_ready = 1'b1;
    step();
    bus0.resp_ready = 1'b0;
    checkOutput("s1_idle_valid", {31'b0, bus0.resp_valid}, 32'd0);
    applyStimulus(1'b0, 32'h10, 32'h0, rd, err);
    checkOutput("s1_load_rd",  rd, 32'h12345678);
    checkOutput("s1_load_err", {31'b0, err}, 32'd0);

    // Scenario 2: misaligned and out-of-range stores are rejected.
    $display("[TB] scenario 2: error responses");
    applyStimulus(1'b1, 32'h13, 32'hFFFFFFFF, rd, err);
    checkOutput("s2_mis_err", {31'b0, err}, 32'd1);
    checkOutput("s2_mis_rd",  rd, 32'd0);
    applyStimulus(1'b1, 32'h100, 32'hFFFFFFFF, rd, err);
    checkOutput("s2_oor_err", {31'b0, err}, 32'd1);
    checkOutput("s2_oor_rd",  rd, 32'd0);
    applyStimulus(1'b0, 32'h10, 32'h0, rd, err);
    checkOutput("s2_load_rd",  rd, 32'h12345678);
    checkOutput("s2_load_err", {31'b0, err}, 32'd0);

    // Scenario 3: response backpressure with a second request waiting.
    $display("[TB] scenario 3: backpressure");
    bus0.req_valid = 1'b1; bus0.req_we = 1'b0;
    bus0.req_a = 32'h10; bus0.req_wd = 32'h0;
    step();
    bus0.req_we = 1'b1; bus0.req_a = 32'h14; bus0.req_wd = 32'h00000077;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      checkOutput("s3_hold_valid", {31'b0, bus0.resp_valid}, 32'd1);
      checkOutput("s3_hold_rd",    bus0.resp_rd, 32'h12345678);
      checkOutput("s3_hold_err",   {31'b0, bus0.resp_err}, 32'd0);
      checkOutput("s3_hold_ready", {31'b0, bus0.req_ready}, 32'd0);
      step();
    end
    bus0.resp_ready = 1'b1;
    checkOutput("s3_hs_ready", {31'b0, bus0.req_ready}, 32'd0);
    step();
    bus0.resp_ready = 1'b0;
    checkOutput("s3_idle_ready", {31'b0, bus0.req_ready}, 32'd1);
    checkOutput("s3_idle_valid", {31'b0, bus0.resp_valid}, 32'd0);
    step();
    bus0.req_valid = 1'b0;
    checkOutput("s3_acc_ready", {31'b0, bus0.req_ready}, 32'd0);
    step();
    step();
    checkOutput("s3_st_valid", {31'b0, bus0.resp_valid}, 32'd1);
    bus0.resp_ready = 1'b1;
    step();
    bus0.resp_ready = 1'b0;
    applyStimulus(1'b0, 32'h14, 32'h0, rd, err);
    checkOutput("s3_load_rd", rd, 32'h00000077);

    // Scenario 4: reset while a store is waiting discards it.
    $display("[TB] scenario 4: reset in WAIT");
    applyStimulus(1'b1, 32'h20, 32'h000000AA, rd, err);
    applyStimulus(1'b0, 32'h10, 32'h0, rd, err);
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1;
    bus0.req_a = 32'h20; bus0.req_wd = 32'hDEADBEEF;
    step();
    bus0.req_valid = 1'b0;
    checkOutput("s4_wait_rd", bus0.resp_rd, 32'h12345678);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s4_async_rd",    bus0.resp_rd, 32'd0);
    checkOutput("s4_async_valid", {31'b0, bus0.resp_valid}, 32'd0);
    checkOutput("s4_async_ready", {31'b0, bus0.req_ready}, 32'd1);
    step();
    step();
    rst_n = 1'b1;
    step();
    applyStimulus(1'b0, 32'h20, 32'h0, rd, err);
    checkOutput("s4_load_rd", rd, 32'h000000AA);

    // Scenario 5: reset in RESP drops the response but keeps the store.
    $display("[TB] scenario 5: reset in RESP");
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1;
    bus0.req_a = 32'h24; bus0.req_wd = 32'h00000055;
    step();
    bus0.req_valid = 1'b0;
    step();
    step();
    checkOutput("s5_resp_valid", {31'b0, bus0.resp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s5_async_valid", {31'b0, bus0.resp_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    applyStimulus(1'b0, 32'h24, 32'h0, rd, err);
    checkOutput("s5_load_rd", rd, 32'h00000055);

    // Scenario 6: zero wait states, back-to-back store/load pairs.
    $display("[TB] scenario 6: zero wait states");
    bus1.resp_ready = 1'b1;
    bus1.req_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus1.req_we = 1'b1; bus1.req_a = 32'h08;
      bus1.req_wd = 32'hCAFE0000 + 32'(i);
      checkOutput("s6_st_ready", {31'b0, bus1.req_ready}, 32'd1);
      step();
      checkOutput("s6_st_valid", {31'b0, bus1.resp_valid}, 32'd1);
      checkOutput("s6_st_rd",    bus1.resp_rd, 32'd0);
      checkOutput("s6_st_busy",  {31'b0, bus1.req_ready}, 32'd0);
      bus1.req_we = 1'b0;
      step();
      checkOutput("s6_ld_ready", {31'b0, bus1.req_ready}, 32'd1);
      checkOutput("s6_idle_valid", {31'b0, bus1.resp_valid}, 32'd0);
      step();
      checkOutput("s6_ld_valid", {31'b0, bus1.resp_valid}, 32'd1);
      checkOutput("s6_ld_rd",    bus1.resp_rd, 32'hCAFE0000 + 32'(i));
      step();
    end
    bus1.req_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
